// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and helpers for the tile scan-out engine.
// Holds default 640x480@60 timing, RGB332 field positions, the palette
// reset pattern and the legal read-latency window.
package vga_pkg;

  // Default 640x480 timing (pixels / lines)
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // RGB332 field slice positions inside a tile byte
  localparam int unsigned R_MSB = 7;
  localparam int unsigned R_LSB = 5;
  localparam int unsigned G_MSB = 4;
  localparam int unsigned G_LSB = 2;
  localparam int unsigned B_MSB = 1;
  localparam int unsigned B_LSB = 0;

  // Tile RAM read latency window supported by the sync/blank pipeline
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;

  // Palette entry reset value: a grey-ish ramp derived from the index
  function automatic logic [7:0] pal_reset_value(input logic [3:0] idx);
    return {idx[3:1], idx[3:1], idx[3:2]};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running h/v counters with raw (undelayed) sync,
// active flag and a registered frame_start pulse at (0,0).
// frame_start stays low on the first (0,0) after reset so the first
// pulse arrives one full frame after reset release.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned H_W      = 10,
  parameter int unsigned V_W      = 10,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_reset,
  output logic [H_W-1:0] o_h,
  output logic [V_W-1:0] o_v,
  output logic           o_hs_raw,
  output logic           o_vs_raw,
  output logic           o_active,
  output logic           o_frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;

  logic [H_W-1:0] r_h;
  logic [V_W-1:0] r_v;
  logic           r_frame_start;
  logic [H_W-1:0] w_h_next;
  logic [V_W-1:0] w_v_next;

  // Next counter position: h wraps at line end, v steps on h wrap
  always_comb begin
    w_h_next = r_h;
    w_v_next = r_v;
    if (r_h == H_W'(H_TOTAL - 1)) begin
      w_h_next = H_W'(0);
      if (r_v == V_W'(V_TOTAL - 1)) begin
        w_v_next = V_W'(0);
      end else begin
        w_v_next = r_v + V_W'(1);
      end
    end else begin
      w_h_next = r_h + H_W'(1);
      w_v_next = r_v;
    end
  end

  // Counter state and frame_start pulse registered alongside it
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_h           <= H_W'(0);
      r_v           <= V_W'(0);
      r_frame_start <= 1'b0;
    end else begin
      r_h           <= w_h_next;
      r_v           <= w_v_next;
      r_frame_start <= (w_h_next == H_W'(0)) && (w_v_next == V_W'(0));
    end
  end

  // Raw sync levels and visible-area flag for the current position
  always_comb begin
    if ((r_h >= H_W'(HS_BEG)) && (r_h < H_W'(HS_END))) begin
      o_hs_raw = HS_POL;
    end else begin
      o_hs_raw = ~HS_POL;
    end
    if ((r_v >= V_W'(VS_BEG)) && (r_v < V_W'(VS_END))) begin
      o_vs_raw = VS_POL;
    end else begin
      o_vs_raw = ~VS_POL;
    end
    o_active = (r_h < H_W'(H_ACTIVE)) && (r_v < V_W'(V_ACTIVE));
  end

  assign o_h           = r_h;
  assign o_v           = r_v;
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vga_tile_reader.sv
// vga_tile_reader: tile-framebuffer scan-out. Walks the tile RAM with
// incremental column/row-base counters, delays sync/blank to match the
// RAM latency and registers RGB332 onto the VGA pins.
// Optional feature macro: VGA_TILE_PALETTE_EN (16-entry palette, pal_* ports).
module vga_tile_reader
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned TILE_SHIFT = 4,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned RD_LATENCY = 1,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0
) (
  input  logic                  clk_25MHz,
  input  logic                  reset,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] r_address,
  input  logic [7:0]            DATA,
  output logic                  VGA_HS,
  output logic                  VGA_VS,
  output logic [2:0]            VGA_R,
  output logic [2:0]            VGA_G,
  output logic [1:0]            VGA_B,
  output logic                  frame_start
`ifdef VGA_TILE_PALETTE_EN
  ,
  input  logic                  pal_mode,
  input  logic                  pal_we,
  input  logic [3:0]            pal_idx,
  input  logic [7:0]            pal_data
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);
  localparam int unsigned TILES_X = H_ACTIVE >> TILE_SHIFT;
  localparam int unsigned TILES_Y = V_ACTIVE >> TILE_SHIFT;

  if ((RD_LATENCY < RD_LAT_MIN) || (RD_LATENCY > RD_LAT_MAX)) begin : g_bad_rd_latency
    $error("vga_tile_reader: RD_LATENCY outside supported range");
  end
  if ((TILES_X * TILES_Y) > (1 << ADDR_WIDTH)) begin : g_bad_addr_width
    $error("vga_tile_reader: ADDR_WIDTH too small for tile map");
  end

  logic [H_W-1:0]        w_h;
  logic [V_W-1:0]        w_v;
  logic                  w_hs_raw;
  logic                  w_vs_raw;
  logic                  w_active;
  logic                  w_frame_start;
  logic                  w_line_end;
  logic                  w_frame_end;
  logic                  w_next_line_active;
  logic [ADDR_WIDTH-1:0] r_col;
  logic [ADDR_WIDTH-1:0] r_row_base;
  logic                  r_en_q;
  logic [RD_LATENCY:0]   r_hs_d;
  logic [RD_LATENCY:0]   r_vs_d;
  logic [RD_LATENCY-1:0] r_act_d;
  logic [7:0]            w_pix;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .H_W (H_W), .V_W (V_W), .HS_POL (HS_POL), .VS_POL (VS_POL)
  ) u_timing (
    .i_clk         (clk_25MHz),
    .i_reset       (reset),
    .o_h           (w_h),
    .o_v           (w_v),
    .o_hs_raw      (w_hs_raw),
    .o_vs_raw      (w_vs_raw),
    .o_active      (w_active),
    .o_frame_start (w_frame_start)
  );

  assign w_line_end  = (w_h == H_W'(H_TOTAL - 1));
  assign w_frame_end = w_line_end && (w_v == V_W'(V_TOTAL - 1));
  // Column only rewinds when the coming line is visible, so the address
  // holds its last in-range value through vertical blanking.
  assign w_next_line_active = (w_v < V_W'(V_ACTIVE - 1)) || (w_v == V_W'(V_TOTAL - 1));

  // Tile address walk: column steps per tile, row base steps per tile row
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_col      <= ADDR_WIDTH'(0);
      r_row_base <= ADDR_WIDTH'(0);
    end else if (w_line_end) begin
      if (w_next_line_active) begin
        r_col <= ADDR_WIDTH'(0);
      end else begin
        r_col <= r_col;
      end
      if (w_frame_end) begin
        r_row_base <= ADDR_WIDTH'(0);
      end else if ((&w_v[TILE_SHIFT-1:0]) && (w_v < V_W'(V_ACTIVE - 1))) begin
        r_row_base <= r_row_base + ADDR_WIDTH'(TILES_X);
      end else begin
        r_row_base <= r_row_base;
      end
    end else if ((w_v < V_W'(V_ACTIVE)) && (w_h < H_W'(H_ACTIVE - 1)) &&
                 (&w_h[TILE_SHIFT-1:0])) begin
      r_col <= r_col + ADDR_WIDTH'(1);
    end else begin
      r_col <= r_col;
    end
  end

  assign r_address = r_row_base + r_col;

  // Video enable is only taken at frame start, never mid-frame
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_en_q <= 1'b0;
    end else if (w_frame_start) begin
      r_en_q <= enable;
    end else begin
      r_en_q <= r_en_q;
    end
  end

  // Sync/active delay line matched to RAM latency plus the colour register
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_hs_d  <= {(RD_LATENCY + 1){~HS_POL}};
      r_vs_d  <= {(RD_LATENCY + 1){~VS_POL}};
      r_act_d <= {RD_LATENCY{1'b0}};
    end else begin
      r_hs_d  <= {r_hs_d[RD_LATENCY-1:0], w_hs_raw};
      r_vs_d  <= {r_vs_d[RD_LATENCY-1:0], w_vs_raw};
      r_act_d <= RD_LATENCY'({r_act_d, w_active});
    end
  end

  assign VGA_HS = r_hs_d[RD_LATENCY];
  assign VGA_VS = r_vs_d[RD_LATENCY];

`ifdef VGA_TILE_PALETTE_EN
  logic [7:0] r_pal [16];

  // Palette register file: reset ramp, single write port
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        r_pal[i] <= pal_reset_value(4'(i));
      end
    end else if (pal_we) begin
      r_pal[pal_idx] <= pal_data;
    end else begin
      r_pal[pal_idx] <= r_pal[pal_idx];
    end
  end

  // Pixel source: palette lookup on the low nibble or direct RGB332
  always_comb begin
    if (pal_mode) begin
      w_pix = r_pal[DATA[3:0]];
    end else begin
      w_pix = DATA;
    end
  end
`else
  // Pixel source: tile byte is direct RGB332
  always_comb begin
    w_pix = DATA;
  end
`endif

  // Colour register: visible and enabled pixels pass, all else is black
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      VGA_R <= 3'b000;
      VGA_G <= 3'b000;
      VGA_B <= 2'b00;
    end else if (r_act_d[RD_LATENCY-1] && r_en_q) begin
      VGA_R <= w_pix[R_MSB:R_LSB];
      VGA_G <= w_pix[G_MSB:G_LSB];
      VGA_B <= w_pix[B_MSB:B_LSB];
    end else begin
      VGA_R <= 3'b000;
      VGA_G <= 3'b000;
      VGA_B <= 2'b00;
    end
  end

  assign frame_start = w_frame_start;

endmodule
